// File: rtl/draw_pkg.sv
// Shared constants and colour helpers for the game-layer renderer.
package draw_pkg;

  localparam int unsigned DEF_SCREEN_W   = 1024;
  localparam int unsigned DEF_TUBE_WIDTH = 120;
  localparam int unsigned DEF_GAP_HEIGHT = 250;
  localparam int unsigned DEF_BIRD_W     = 40;
  localparam int unsigned DEF_BIRD_H     = 50;

  localparam logic [10:0] OFFSCREEN = 11'h7FF;

  // Per-player bird colour.
  function automatic logic [11:0] bird_rgb(input logic [1:0] idx);
    case (idx)
      2'd0:    return 12'h00F;
      2'd1:    return 12'hFF0;
      2'd2:    return 12'hF00;
      default: return 12'hF0F;
    endcase
  endfunction

  // Tube body colour banded by column offset from the tube's left edge.
  function automatic logic [11:0] tube_shade(input logic [10:0] rel_x,
                                             input int unsigned width);
    int unsigned r;
    r = 32'(rel_x);
    if (r < 5 || r >= width - 5) return 12'h000;
    else if (r < 20)             return 12'h0F0;
    else if (r < 40)             return 12'h0C0;
    else if (r < 80)             return 12'h090;
    else                         return 12'h0D0;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing plus pixel bundle passed between display stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_scene_pipe_hit.sv
// Rectangle hit test against the current raster position.
// INV_Y selects the tube form: inside the column but outside [y, y+H].
module draw_obj_hit #(
  parameter int unsigned W     = 40,
  parameter int unsigned H     = 50,
  parameter bit          INV_Y = 1'b0
) (
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        hit
);

  logic [11:0] x_end;
  logic [11:0] y_end;
  logic        x_in;
  logic        y_in;

  assign x_end = {1'b0, x} + 12'(W);
  assign y_end = {1'b0, y} + 12'(H);

  // Compare in 12 bits so right/bottom edges never wrap.
  always_comb begin
    x_in = (hcount >= x) && ({1'b0, hcount} < x_end);
    if (INV_Y) begin
      y_in = (vcount >= y) && ({1'b0, vcount} <= y_end);
      hit  = x_in & ~y_in;
    end else begin
      y_in = (vcount >= y) && ({1'b0, vcount} < y_end);
      hit  = x_in & y_in;
    end
  end

endmodule

// File: rtl/draw_scene_pipe.sv
// Two-stage overlay of tubes and birds onto the VGA stream, with
// per-frame position snapshots and a blinking pending bird.
module draw_scene_pipe
  import draw_pkg::*;
#(
  parameter int unsigned N_TUBES      = 3,
  parameter int unsigned N_BIRDS      = 2,
  parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
  parameter int unsigned TUBE_WIDTH   = DEF_TUBE_WIDTH,
  parameter int unsigned GAP_HEIGHT   = DEF_GAP_HEIGHT,
  parameter int unsigned BIRD_W       = DEF_BIRD_W,
  parameter int unsigned BIRD_H       = DEF_BIRD_H,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned PB_W         = (N_BIRDS > 1) ? $clog2(N_BIRDS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  vga_if.in                         vin,
  vga_if.out                        vout,
  input  logic [N_TUBES-1:0][10:0]  tube_x,
  input  logic [N_TUBES-1:0][10:0]  gap_y,
  input  logic [N_BIRDS-1:0][10:0]  bird_x,
  input  logic [N_BIRDS-1:0][10:0]  bird_y,
  input  logic                      pending,
  input  logic [PB_W-1:0]           pending_bird
);

  localparam int unsigned FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic                     vblnk_q;
  logic                     vblnk_rise;
  logic [N_TUBES-1:0][10:0] sh_tube_x;
  logic [N_TUBES-1:0][10:0] sh_gap_y;
  logic [N_BIRDS-1:0][10:0] sh_bird_x;
  logic [N_BIRDS-1:0][10:0] sh_bird_y;
  logic                     sh_pending;
  logic [PB_W-1:0]          sh_pending_bird;
  logic [FCW-1:0]           frame_cnt;
  logic                     blink_on;

  logic [N_TUBES-1:0]       tube_rect_hit;
  logic [N_TUBES-1:0]       tube_hit;
  logic [N_TUBES-1:0][10:0] tube_rel;
  logic [N_BIRDS-1:0]       bird_rect_hit;
  logic [N_BIRDS-1:0]       bird_vis;
  logic                     blank;

  logic [10:0]              s1_hcount;
  logic [10:0]              s1_vcount;
  logic                     s1_hsync;
  logic                     s1_vsync;
  logic                     s1_hblnk;
  logic                     s1_vblnk;
  logic [11:0]              s1_rgb;
  logic [N_TUBES-1:0]       s1_tube_hit;
  logic [N_TUBES-1:0][10:0] s1_tube_rel;
  logic [N_BIRDS-1:0]       s1_bird_hit;

  logic [11:0]              rgb_sel;
  logic                     found;

  assign vblnk_rise = vin.vblnk & ~vblnk_q;
  assign blank      = vin.hblnk | vin.vblnk;

  // Frame-edge snapshot of object positions and blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q         <= 1'b0;
      sh_tube_x       <= {N_TUBES{OFFSCREEN}};
      sh_gap_y        <= '0;
      sh_bird_x       <= '0;
      sh_bird_y       <= {N_BIRDS{OFFSCREEN}};
      sh_pending      <= 1'b0;
      sh_pending_bird <= '0;
      frame_cnt       <= '0;
      blink_on        <= 1'b1;
    end else begin
      vblnk_q <= vin.vblnk;
      if (vblnk_rise) begin
        sh_tube_x       <= tube_x;
        sh_gap_y        <= gap_y;
        sh_bird_x       <= bird_x;
        sh_bird_y       <= bird_y;
        sh_pending      <= pending;
        sh_pending_bird <= pending_bird;
        if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_TUBES; g++) begin : g_tube
    draw_obj_hit #(
      .W     (TUBE_WIDTH),
      .H     (GAP_HEIGHT),
      .INV_Y (1'b1)
    ) u_hit (
      .hcount (vin.hcount),
      .vcount (vin.vcount),
      .x      (sh_tube_x[g]),
      .y      (sh_gap_y[g]),
      .hit    (tube_rect_hit[g])
    );
    assign tube_hit[g] = tube_rect_hit[g] & ({1'b0, sh_tube_x[g]} < 12'(SCREEN_W));
    assign tube_rel[g] = vin.hcount - sh_tube_x[g];
  end

  for (genvar g = 0; g < N_BIRDS; g++) begin : g_bird
    draw_obj_hit #(
      .W     (BIRD_W),
      .H     (BIRD_H),
      .INV_Y (1'b0)
    ) u_hit (
      .hcount (vin.hcount),
      .vcount (vin.vcount),
      .x      (sh_bird_x[g]),
      .y      (sh_bird_y[g]),
      .hit    (bird_rect_hit[g])
    );
    // Blink mask is folded in here so stage 2 only sees visible birds.
    assign bird_vis[g] = bird_rect_hit[g] &
                         ~(sh_pending & (sh_pending_bird == PB_W'(g)) & ~blink_on);
  end

  // Stage 1: register the stream alongside per-object hit results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hcount   <= '0;
      s1_vcount   <= '0;
      s1_hsync    <= 1'b0;
      s1_vsync    <= 1'b0;
      s1_hblnk    <= 1'b0;
      s1_vblnk    <= 1'b0;
      s1_rgb      <= '0;
      s1_tube_hit <= '0;
      s1_tube_rel <= '0;
      s1_bird_hit <= '0;
    end else begin
      s1_hcount   <= vin.hcount;
      s1_vcount   <= vin.vcount;
      s1_hsync    <= vin.hsync;
      s1_vsync    <= vin.vsync;
      s1_hblnk    <= vin.hblnk;
      s1_vblnk    <= vin.vblnk;
      s1_rgb      <= vin.rgb;
      s1_tube_hit <= blank ? '0 : tube_hit;
      s1_tube_rel <= tube_rel;
      s1_bird_hit <= blank ? '0 : bird_vis;
    end
  end

  // Stage 2 priority: lowest visible bird, then lowest tube, then background.
  always_comb begin
    rgb_sel = s1_rgb;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_BIRDS; i++) begin
      if (s1_bird_hit[i] && !found) begin
        rgb_sel = bird_rgb(2'(i));
        found   = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_TUBES; i++) begin
      if (s1_tube_hit[i] && !found) begin
        rgb_sel = tube_shade(s1_tube_rel[i], TUBE_WIDTH);
        found   = 1'b1;
      end
    end
  end

  // Stage 2 register: drive the output stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout.hcount <= '0;
      vout.vcount <= '0;
      vout.hsync  <= 1'b0;
      vout.vsync  <= 1'b0;
      vout.hblnk  <= 1'b0;
      vout.vblnk  <= 1'b0;
      vout.rgb    <= '0;
    end else begin
      vout.hcount <= s1_hcount;
      vout.vcount <= s1_vcount;
      vout.hsync  <= s1_hsync;
      vout.vsync  <= s1_vsync;
      vout.hblnk  <= s1_hblnk;
      vout.vblnk  <= s1_vblnk;
      vout.rgb    <= rgb_sel;
    end
  end

endmodule

// File: tb/tb_draw_scene_pipe.sv
// Randomized bench for draw_scene_pipe against a behavioural frame model.
module tb_draw_scene_pipe;

  localparam int unsigned NT = 3;
  localparam int unsigned NB = 2;
  localparam int unsigned BF = 2;
  localparam int SW = 1024;
  localparam int TW = 120;
  localparam int GH = 250;
  localparam int BW = 40;
  localparam int BH = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_if vin_if ();
  vga_if vout_if ();

  logic [NT-1:0][10:0] tube_x;
  logic [NT-1:0][10:0] gap_y;
  logic [NB-1:0][10:0] bird_x;
  logic [NB-1:0][10:0] bird_y;
  logic                pending;
  logic [0:0]          pending_bird;

  draw_scene_pipe #(
    .N_TUBES      (NT),
    .N_BIRDS      (NB),
    .SCREEN_W     (SW),
    .TUBE_WIDTH   (TW),
    .GAP_HEIGHT   (GH),
    .BIRD_W       (BW),
    .BIRD_H       (BH),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vin          (vin_if),
    .vout         (vout_if),
    .tube_x       (tube_x),
    .gap_y        (gap_y),
    .bird_x       (bird_x),
    .bird_y       (bird_y),
    .pending      (pending),
    .pending_bird (pending_bird)
  );

  // Reference model state: the positions the current frame is drawn with.
  int  m_tx [NT];
  int  m_gy [NT];
  int  m_bx [NB];
  int  m_by [NB];
  bit  m_pend;
  int  m_pb;
  int  m_frames;
  bit  m_vb_prev;

  logic [37:0] expq [$];
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [37:0] got, input logic [37:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] pal(input int j);
    case (j)
      0:       return 12'h00F;
      1:       return 12'hFF0;
      2:       return 12'hF00;
      default: return 12'hF0F;
    endcase
  endfunction

  function automatic logic [11:0] shade(input int rel);
    if (rel < 5 || rel >= TW - 5) return 12'h000;
    if (rel < 20) return 12'h0F0;
    if (rel < 40) return 12'h0C0;
    if (rel < 80) return 12'h090;
    return 12'h0D0;
  endfunction

  // Blink phase: visible for BF frames, hidden for BF frames, counted from reset.
  function automatic logic [11:0] model_rgb(input int hc, input int vc, input logic hb,
                                            input logic vb, input logic [11:0] rgb_in);
    bit blink;
    blink = ((m_frames / BF) % 2) == 0;
    if (hb || vb) return rgb_in;
    for (int j = 0; j < NB; j++) begin
      if (hc >= m_bx[j] && hc < m_bx[j] + BW && vc >= m_by[j] && vc < m_by[j] + BH &&
          !(m_pend && m_pb == j && !blink))
        return pal(j);
    end
    for (int i = 0; i < NT; i++) begin
      if (m_tx[i] < SW && hc >= m_tx[i] && hc < m_tx[i] + TW &&
          (vc < m_gy[i] || vc > m_gy[i] + GH))
        return shade(hc - m_tx[i]);
    end
    return rgb_in;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin m_tx[i] = 2047; m_gy[i] = 0; end
    for (int j = 0; j < NB; j++) begin m_bx[j] = 0; m_by[j] = 2047; end
    m_pend    = 1'b0;
    m_pb      = 0;
    m_frames  = 0;
    m_vb_prev = 1'b0;
  endtask

  // One pixel clock: drive, predict, clock, then compare the output 2 clk old.
  task automatic cyc(input int hc, input int vc, input logic hb, input logic vb);
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic [37:0] exp;
    rgb = 12'($urandom);
    hs  = 1'($urandom);
    vs  = 1'($urandom);
    vin_if.hcount = 11'(hc);
    vin_if.vcount = 11'(vc);
    vin_if.hsync  = hs;
    vin_if.vsync  = vs;
    vin_if.hblnk  = hb;
    vin_if.vblnk  = vb;
    vin_if.rgb    = rgb;
    expq.push_back({11'(hc), 11'(vc), hs, vs, hb, vb, model_rgb(hc, vc, hb, vb, rgb)});
    @(posedge clk);
    if (vb && !m_vb_prev) begin
      for (int i = 0; i < NT; i++) begin m_tx[i] = int'(tube_x[i]); m_gy[i] = int'(gap_y[i]); end
      for (int j = 0; j < NB; j++) begin m_bx[j] = int'(bird_x[j]); m_by[j] = int'(bird_y[j]); end
      m_pend = pending;
      m_pb   = int'(pending_bird);
      m_frames++;
    end
    m_vb_prev = vb;
    #1;
    if (expq.size() >= 2) begin
      exp = expq.pop_front();
      check_val("rgb", 38'(vout_if.rgb), 38'(exp[11:0]));
      check_val("ctl", 38'({vout_if.hcount, vout_if.vcount, vout_if.hsync, vout_if.vsync,
                            vout_if.hblnk, vout_if.vblnk}), 38'(exp[37:12]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_val("rst_vout", {vout_if.hcount, vout_if.vcount, vout_if.hsync, vout_if.vsync,
                           vout_if.hblnk, vout_if.vblnk, vout_if.rgb}, '0);
    expq.delete();
    model_reset();
    expq.push_back('0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic frame_edge();
    for (int k = 0; k < 3; k++)
      cyc($urandom_range(0, 1343), $urandom_range(768, 805), 1'b1, 1'b1);
  endtask

  task automatic probe(input int hc, input int vc);
    cyc(hc, vc, 1'b0, 1'b0);
  endtask

  task automatic rand_px(input int n);
    int hc;
    for (int k = 0; k < n; k++) begin
      hc = $urandom_range(0, 1343);
      cyc(hc, $urandom_range(0, 767), hc >= SW, 1'b0);
    end
  endtask

  task automatic park_all();
    for (int i = 0; i < NT; i++) begin tube_x[i] = 11'h7FF; gap_y[i] = '0; end
    for (int j = 0; j < NB; j++) begin bird_x[j] = '0; bird_y[j] = 11'h7FF; end
  endtask

  initial begin
    vin_if.hcount = '0; vin_if.vcount = '0; vin_if.hsync = 1'b0; vin_if.vsync = 1'b0;
    vin_if.hblnk = 1'b0; vin_if.vblnk = 1'b0; vin_if.rgb = '0;
    park_all();
    pending = 1'b0;
    pending_bird = '0;
    model_reset();

    // Reset, then visible positions presented without a frame edge.
    do_reset();
    tube_x[0] = 11'd100; gap_y[0] = 11'd300;
    bird_x[0] = 11'd100; bird_y[0] = 11'd100;
    rand_px(20);
    // Reset asserted mid-line.
    do_reset();
    rand_px(10);

    // Single tube shading and gap boundaries.
    park_all();
    tube_x[0] = 11'd200; gap_y[0] = 11'd300;
    frame_edge();
    probe(205, 100); probe(202, 100); probe(250, 400); probe(250, 551);
    probe(250, 550); probe(250, 300); probe(250, 299); probe(204, 100);
    probe(319, 100); probe(320, 100); probe(315, 100); probe(199, 100);

    // Right-edge clipping and fully offscreen tube.
    park_all();
    tube_x[1] = 11'd1014; tube_x[2] = 11'd1030;
    frame_edge();
    for (int h = 1008; h < 1045; h++) cyc(h, 600, h >= SW, 1'b0);

    // Overlap priority and pending bird0 blink.
    park_all();
    tube_x[0] = 11'd150; gap_y[0] = 11'd400;
    bird_x[0] = 11'd180; bird_y[0] = 11'd180;
    bird_x[1] = 11'd190; bird_y[1] = 11'd190;
    frame_edge();
    probe(200, 200); probe(185, 185); probe(225, 235);
    pending = 1'b1; pending_bird = 1'b0;
    for (int f = 0; f < 5; f++) begin
      frame_edge();
      probe(200, 200); probe(185, 185); probe(229, 239);
    end

    // Pending bird1 blink cadence; bird0 unaffected.
    park_all();
    bird_x[0] = 11'd100; bird_y[0] = 11'd600;
    bird_x[1] = 11'd500; bird_y[1] = 11'd600;
    pending_bird = 1'b1;
    for (int f = 0; f < 8; f++) begin
      frame_edge();
      probe(510, 610); probe(110, 610);
    end

    // Mid-frame position change is deferred to the next frame.
    pending = 1'b0;
    frame_edge();
    probe(510, 610);
    bird_y[1] = 11'd700;
    probe(510, 610); probe(510, 710);
    frame_edge();
    probe(510, 610); probe(510, 710);

    // Random scenes with mid-frame position churn.
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NT; i++) begin
        tube_x[i] = 11'($urandom_range(0, 1100));
        gap_y[i]  = 11'($urandom_range(0, 700));
      end
      for (int j = 0; j < NB; j++) begin
        bird_x[j] = 11'($urandom_range(0, 1023));
        bird_y[j] = 11'($urandom_range(0, 767));
      end
      pending      = 1'($urandom);
      pending_bird = 1'($urandom);
      frame_edge();
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 39) == 0) begin
          tube_x[0] = 11'($urandom_range(0, 1100));
          bird_y[0] = 11'($urandom_range(0, 767));
          pending   = 1'($urandom);
        end
        rand_px(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
